reg_file_flags: RTL and testbench

//  Operand register file plus carry/borrow/zero flag register; sits around the ALU.
//  Two read ports drive the ALU operands IN_A/IN_B. The write port takes the ALU OUT.
//  The flag register latches ALU Cout/Bout and drives the ALU Cin/Bin of the next instruction.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/flag_reg.sv | 51 +++++
 rtl/reg_file_flags.sv | 66 ++++++
 tb/tb_reg_file_flags.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants: default widths and flag bit positions.
package cpu_pkg;

  localparam int DWIDTH = 8;
  localparam int AWIDTH = 3;

  localparam int FLAG_W = 3;
  localparam int FLG_C  = 0;
  localparam int FLG_B  = 1;
  localparam int FLG_Z  = 2;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/flag_reg.sv
// Carry/borrow/zero flag register with a one-entry shadow copy for save/restore.
module flag_reg
  import cpu_pkg::*;
#(
  parameter int DWIDTH = cpu_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              cout_in,
  input  logic              bout_in,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              clr_flags,
  input  logic              save,
  input  logic              restore,
  output flags_t            flags
);

  flags_t shadow;
  flags_t alu_flags;

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_C] = cout_in;
    alu_flags[FLG_B] = bout_in;
    // Zero follows the ALU result even when it is not written back (compare ops).
    alu_flags[FLG_Z] = (wdata == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (restore) begin
      flags <= shadow;
    end else if (clr_flags) begin
      flags <= '0;
    end else if (flag_we) begin
      flags <= alu_flags;
    end
  end

  // Saving captures the pre-edge flags, so save+restore swaps the two copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (save) begin
      shadow <= flags;
    end
  end

endmodule

// File: rtl/reg_file_flags.sv
// Two-read/one-write operand register file with the ALU flag register alongside.
module reg_file_flags
  import cpu_pkg::*;
#(
  parameter int DWIDTH = cpu_pkg::DWIDTH,
  parameter int AWIDTH = cpu_pkg::AWIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [DWIDTH-1:0] WDATA,
  input  logic [AWIDTH-1:0] RADDR_A,
  input  logic [AWIDTH-1:0] RADDR_B,
  output logic [DWIDTH-1:0] OUT_A,
  output logic [DWIDTH-1:0] OUT_B,
  input  logic              FLAG_WE,
  input  logic              COUT_IN,
  input  logic              BOUT_IN,
  input  logic              CLR_FLAGS,
  input  logic              SAVE,
  input  logic              RESTORE,
  output logic              C_FLAG,
  output logic              B_FLAG,
  output logic              Z_FLAG
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] regs [DEPTH];
  flags_t            flags;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WE) begin
      regs[WADDR] <= WDATA;
    end
  end

  // Reads are unbypassed: a same-cycle write shows up only after the edge.
  assign OUT_A = regs[RADDR_A];
  assign OUT_B = regs[RADDR_B];

  flag_reg #(
    .DWIDTH(DWIDTH)
  ) u_flag_reg (
    .clk       (CLK),
    .rst_n     (RST),
    .flag_we   (FLAG_WE),
    .cout_in   (COUT_IN),
    .bout_in   (BOUT_IN),
    .wdata     (WDATA),
    .clr_flags (CLR_FLAGS),
    .save      (SAVE),
    .restore   (RESTORE),
    .flags     (flags)
  );

  assign C_FLAG = flags[FLG_C];
  assign B_FLAG = flags[FLG_B];
  assign Z_FLAG = flags[FLG_Z];

endmodule

// File: tb/tb_reg_file_flags.sv
// Directed bench for reg_file_flags: register reads/writes, flag priority, shadow save/restore, async reset.
module tb_reg_file_flags;

  logic       CLK;
  logic       RST;
  logic       WE;
  logic [2:0] WADDR;
  logic [7:0] WDATA;
  logic [2:0] RADDR_A;
  logic [2:0] RADDR_B;
  logic [7:0] OUT_A;
  logic [7:0] OUT_B;
  logic       FLAG_WE;
  logic       COUT_IN;
  logic       BOUT_IN;
  logic       CLR_FLAGS;
  logic       SAVE;
  logic       RESTORE;
  logic       C_FLAG;
  logic       B_FLAG;
  logic       Z_FLAG;

  int tests;
  int fails;
  logic [7:0] model [8];

  reg_file_flags dut (
    .CLK       (CLK),
    .RST       (RST),
    .WE        (WE),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .RADDR_A   (RADDR_A),
    .RADDR_B   (RADDR_B),
    .OUT_A     (OUT_A),
    .OUT_B     (OUT_B),
    .FLAG_WE   (FLAG_WE),
    .COUT_IN   (COUT_IN),
    .BOUT_IN   (BOUT_IN),
    .CLR_FLAGS (CLR_FLAGS),
    .SAVE      (SAVE),
    .RESTORE   (RESTORE),
    .C_FLAG    (C_FLAG),
    .B_FLAG    (B_FLAG),
    .Z_FLAG    (Z_FLAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge, outputs are sampled later in the cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE = 0; WADDR = 0; WDATA = 8'h01;
    FLAG_WE = 0; COUT_IN = 0; BOUT_IN = 0;
    CLR_FLAGS = 0; SAVE = 0; RESTORE = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RADDR_A = 0; RADDR_B = 0;
    RST = 0;
    #12;
    for (int i = 0; i < 8; i++) begin
      RADDR_A = i[2:0]; RADDR_B = 3'(7 - i);
      #1;
      tests++;
      if (OUT_A !== 8'h00 || OUT_B !== 8'h00) begin
        $display("[TB] FAIL reset_read addr %0d: OUT_A=%h OUT_B=%h required 00/00", i, OUT_A, OUT_B);
        fails++;
      end
    end
    tests++;
    if ({C_FLAG, B_FLAG, Z_FLAG} !== 3'b000) begin
      $display("[TB] FAIL reset_flags: CBZ=%b required 000", {C_FLAG, B_FLAG, Z_FLAG});
      fails++;
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    @(negedge CLK);
    RST = 1;
    tick();
  endtask

  task automatic test_write_read();
    WE = 1; WADDR = 3; WDATA = 8'hA5; RADDR_A = 3; RADDR_B = 0;
    #1;
    tests++;
    if (OUT_A !== 8'h00) begin
      $display("[TB] FAIL no_bypass: OUT_A=%h required 00", OUT_A);
      fails++;
    end
    tick();
    model[3] = 8'hA5;
    WE = 0;
    #1;
    tests++;
    if (OUT_A !== 8'hA5) begin
      $display("[TB] FAIL write_visible: OUT_A=%h required a5", OUT_A);
      fails++;
    end
    RADDR_B = 3;
    #1;
    tests++;
    if (OUT_B !== 8'hA5 || OUT_A !== 8'hA5) begin
      $display("[TB] FAIL same_addr_both_ports: OUT_A=%h OUT_B=%h required a5/a5", OUT_A, OUT_B);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [8];
    vals = '{8'h5A, 8'h11, 8'hFF, 8'hC3, 8'h80, 8'h01, 8'h7E, 8'h24};
    for (int i = 0; i < 8; i++) begin
      WE = 1; WADDR = i[2:0]; WDATA = vals[i];
      tick();
      model[i] = vals[i];
    end
    WE = 0;
    for (int i = 0; i < 8; i++) begin
      RADDR_A = i[2:0]; RADDR_B = 3'(7 - i);
      #1;
      tests++;
      if (OUT_A !== model[i] || OUT_B !== model[7 - i]) begin
        $display("[TB] FAIL b2b_read %0d: OUT_A=%h OUT_B=%h required %h/%h",
                 i, OUT_A, OUT_B, model[i], model[7 - i]);
        fails++;
      end
    end
  endtask

  task automatic test_add_flags();
    FLAG_WE = 1; COUT_IN = 1; BOUT_IN = 0; WE = 1; WADDR = 1; WDATA = 8'h00;
    #1;
    tests++;
    if (C_FLAG !== 1'b0) begin
      $display("[TB] FAIL flag_registered: C_FLAG=%b required 0 before edge", C_FLAG);
      fails++;
    end
    tick();
    model[1] = 8'h00;
    idle_inputs();
    RADDR_A = 1;
    #1;
    tests++;
    if ({C_FLAG, B_FLAG, Z_FLAG} !== 3'b101 || OUT_A !== 8'h00) begin
      $display("[TB] FAIL add_flags: CBZ=%b OUT_A=%h required 101/00", {C_FLAG, B_FLAG, Z_FLAG}, OUT_A);
      fails++;
    end
  endtask

  task automatic test_sub_compare();
    FLAG_WE = 1; COUT_IN = 0; BOUT_IN = 1; WE = 0; WADDR = 2; WDATA = 8'hE4;
    tick();
    idle_inputs();
    #1;
    tests++;
    if ({C_FLAG, B_FLAG, Z_FLAG} !== 3'b010) begin
      $display("[TB] FAIL sub_flags: CBZ=%b required 010", {C_FLAG, B_FLAG, Z_FLAG});
      fails++;
    end
    for (int i = 0; i < 8; i++) begin
      RADDR_A = i[2:0];
      #1;
      tests++;
      if (OUT_A !== model[i]) begin
        $display("[TB] FAIL compare_no_write %0d: OUT_A=%h required %h", i, OUT_A, model[i]);
        fails++;
      end
    end
  endtask

  task automatic check_flags(input string name, input logic [2:0] cbz);
    tests++;
    if ({C_FLAG, B_FLAG, Z_FLAG} !== cbz) begin
      $display("[TB] FAIL %s: CBZ=%b required %b", name, {C_FLAG, B_FLAG, Z_FLAG}, cbz);
      fails++;
    end
  endtask

  task automatic test_save_restore();
    FLAG_WE = 1; COUT_IN = 1; BOUT_IN = 0; WDATA = 8'h42;
    tick();
    idle_inputs();
    check_flags("setup_100", 3'b100);
    SAVE = 1; FLAG_WE = 1; COUT_IN = 0; BOUT_IN = 1; WDATA = 8'h42;
    tick();
    idle_inputs();
    check_flags("save_with_flag_we", 3'b010);
    RESTORE = 1;
    tick();
    idle_inputs();
    check_flags("restore", 3'b100);
    FLAG_WE = 1; COUT_IN = 0; BOUT_IN = 1; WDATA = 8'h00;
    tick();
    idle_inputs();
    check_flags("setup_011", 3'b011);
    SAVE = 1; RESTORE = 1;
    tick();
    idle_inputs();
    check_flags("swap_flags", 3'b100);
    RESTORE = 1;
    tick();
    idle_inputs();
    check_flags("swap_shadow", 3'b011);
  endtask

  task automatic test_clr_priority();
    CLR_FLAGS = 1; FLAG_WE = 1; COUT_IN = 1; WDATA = 8'h00;
    tick();
    idle_inputs();
    check_flags("clr_over_flag_we", 3'b000);
    RESTORE = 1; CLR_FLAGS = 1;
    tick();
    idle_inputs();
    check_flags("restore_over_clr", 3'b011);
    tick();
    check_flags("hold", 3'b011);
  endtask

  task automatic test_reset_midrun();
    #2;
    RST = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      RADDR_A = i[2:0]; RADDR_B = i[2:0];
      #1;
      tests++;
      if (OUT_A !== 8'h00 || OUT_B !== 8'h00) begin
        $display("[TB] FAIL midrun_reset_read %0d: OUT_A=%h OUT_B=%h required 00/00", i, OUT_A, OUT_B);
        fails++;
      end
    end
    check_flags("midrun_reset_flags", 3'b000);
    WE = 1; WADDR = 5; WDATA = 8'h77;
    @(posedge CLK);
    #3;
    RST = 1;
    WE = 0;
    RADDR_A = 5;
    #1;
    tests++;
    if (OUT_A !== 8'h00) begin
      $display("[TB] FAIL write_during_reset: OUT_A=%h required 00", OUT_A);
      fails++;
    end
    RESTORE = 1;
    tick();
    idle_inputs();
    check_flags("shadow_cleared", 3'b000);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_add_flags();
    test_sub_compare();
    test_save_restore();
    test_clr_priority();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
